// File: rtl/i_prefetch.sv
// Instruction prefetch buffer: single-outstanding fetches into a small FIFO of
// {instruction, pc+4} pairs, flushed on a decode redirect.
module i_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              target,
    input  logic                     stall,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              pc_plus_four,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    fifo_instr [DEPTH];
    logic [31:0]    fifo_pc4   [DEPTH];
    logic           push;
    logic           pop;

    // Redirect wins over both push and pop in the cycle it is seen.
    assign push = (state == WAIT) && mem_ack && !redirect;
    assign pop  = instr_valid && !stall && !redirect;

    assign mem_req      = (state == REQ);
    assign mem_addr     = fetch_pc;
    assign instr_valid  = (count != '0);
    assign instr        = instr_valid ? fifo_instr[rd_ptr] : '0;
    assign pc_plus_four = instr_valid ? fifo_pc4[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect)              fetch_pc <= target;
                    else if (count < DEPTH_C)  state    <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        state    <= DISCARD;
                    end else begin
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fetch_pc <= redirect ? target : fetch_pc + 32'd4;
                        state    <= IDLE;
                    end else if (redirect) begin
                        fetch_pc <= target;
                        state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    // The in-flight word belongs to the old stream; swallow its ack.
                    if (redirect) fetch_pc <= target;
                    if (mem_ack)  state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= mem_rdata;
            fifo_pc4[wr_ptr]   <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_i_prefetch.sv
// Bench for i_prefetch: random memory latency, stalls and redirects checked
// against a transaction-level queue model, plus directed reset/full/redirect cases.
module tb_i_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus_four;
    logic [2:0]  count;

    always #5 clk = ~clk;

    i_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
        .target(target), .stall(stall), .instr_valid(instr_valid),
        .instr(instr), .pc_plus_four(pc_plus_four), .count(count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: queue of {instr, pc+4}, next fetch address, request bookkeeping
    logic [63:0] q[$];
    logic [31:0] m_pc = RPC;
    bit          m_busy, m_stale;
    // memory model
    bit          mp;
    int          mw;
    logic [31:0] ma;
    // knobs and bookkeeping
    int          lat_min = 1, lat_max = 1, p_stall = 0, p_redir = 0, redir_mode = 0;
    logic [31:0] r_tgt;
    bit          stream_chk, first_after_rst, prev_req, r_idle;
    int          last_req = -1, cyc_n = 0, redir_cyc = -100, pushes = 0;

    task automatic cyc();
        bit          req, ack, rd, st, accept;
        logic [31:0] tg, rdat;
        logic [63:0] h;
        @(negedge clk);
        cyc_n++;
        h = (q.size() != 0) ? q[0] : 64'd0;
        chk("count", 32'(count), 32'(q.size()));
        chk("valid", 32'(instr_valid), 32'(q.size() != 0));
        chk("instr", instr, h[63:32]);
        chk("pc4", pc_plus_four, h[31:0]);
        chk("addr", mem_addr, m_pc);
        req = mem_req;
        if (req) chk("req_gate", 32'(!m_busy && q.size() < DEPTH), 32'd1);
        if (first_after_rst) begin
            chk("first_req", 32'(req), 32'd1);
            first_after_rst = 0;
        end
        if (cyc_n - redir_cyc == 1) chk("redir_req1", 32'(req), 32'd0);
        if (cyc_n - redir_cyc == 2 && r_idle) chk("redir_req2", 32'(req), 32'd1);
        if (stream_chk && req) begin
            if (last_req >= 0) chk("spacing", 32'(cyc_n - last_req), 32'd3);
            last_req = cyc_n;
        end

        ack = 0;
        if (mp) begin
            mw--;
            if (mw == 0) begin ack = 1; mp = 0; end
        end
        if (req) begin
            mp = 1;
            mw = $urandom_range(lat_max, lat_min);
            ma = mem_addr;
        end
        rdat = ack ? 32'h1000_0000 + ma : $urandom;
        st   = ($urandom_range(99, 0) < p_stall);
        rd   = ($urandom_range(99, 0) < p_redir);
        tg   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
        if (redir_mode == 1 && prev_req) begin rd = 1; tg = r_tgt; redir_mode = 0; end
        if (redir_mode == 2 && ack)      begin rd = 1; tg = r_tgt; redir_mode = 0; end
        prev_req  = req;
        mem_ack   = ack;
        mem_rdata = rdat;
        stall     = st;
        redirect  = rd;
        target    = tg;

        accept = 0;
        if (ack) begin
            accept = m_busy && !m_stale && !rd;
            m_busy = 0;
            m_stale = 0;
        end
        if (req) begin m_busy = 1; m_stale = 0; end
        if (rd) begin
            q.delete();
            m_pc = tg;
            if (m_busy) m_stale = 1;
            redir_cyc = cyc_n;
            r_idle = !m_busy;
        end else begin
            if (q.size() != 0 && !st) void'(q.pop_front());
            if (accept) begin
                q.push_back({rdat, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
                pushes++;
            end
        end
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic reset_dut(input bit stale_ack);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_ack = 1'b0;
        redirect = 1'b0;
        stall = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc4", pc_plus_four, 32'd0);
        chk("rst_addr", mem_addr, RPC);
        repeat (2) @(negedge clk);
        q.delete();
        m_pc = RPC; m_busy = 0; m_stale = 0; mp = 0;
        redir_cyc = -100; prev_req = 0; last_req = -1; redir_mode = 0;
        first_after_rst = 1;
        rst_n = 1'b1;
        if (stale_ack) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    initial begin
        int n;
        reset_dut(0);
        stream_chk = 1;
        repeat (12) cyc();
        stream_chk = 0;

        reset_dut(0);
        p_stall = 100;
        repeat (20) cyc();
        chk("full_cnt", 32'(count), 32'd4);
        chk("full_addr", mem_addr, 32'h10);
        chk("full_noreq", 32'(mem_req), 32'd0);
        p_stall = 0;
        repeat (12) cyc();

        lat_min = 3; lat_max = 3; r_tgt = 32'h100; redir_mode = 1;
        repeat (15) cyc();
        chk("redir_wait_fired", 32'(redir_mode), 32'd0);

        lat_min = 1; lat_max = 1; r_tgt = 32'h200; redir_mode = 2;
        repeat (12) cyc();
        chk("redir_ack_fired", 32'(redir_mode), 32'd0);

        lat_min = 1; lat_max = 3; p_stall = 30; p_redir = 8;
        repeat (3000) cyc();

        p_stall = 0; p_redir = 0; lat_min = 3; lat_max = 3;
        n = 0;
        do begin cyc(); n++; end while (!prev_req && n < 50);
        chk("wait_found", 32'(prev_req), 32'd1);
        reset_dut(1);
        lat_min = 1; lat_max = 1;
        repeat (12) cyc();

        chk("pushes", 32'(pushes > 100), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i_prefetch.md
# i_prefetch

Instruction prefetch buffer sitting directly upstream of `i_fetch` in the pipeline datapath. It issues single-outstanding word requests to instruction memory, which may have variable latency, and queues the returned instructions with their PC+4 in a small FIFO. It presents the head entry to the fetch/decode boundary and flushes on a taken jump or branch redirect from decode.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  one-cycle request strobe to instruction memory.
- `mem_addr`  out  32  fetch address; always equals internal `fetch_pc`.
- `mem_ack`  in  1  memory returns data for the outstanding request this cycle.
- `mem_rdata`  in  32  instruction word; valid when `mem_ack`=1.
- `redirect`  in  1  taken jump or branch, driven by decode's `jump_or_branch`.
- `target`  in  32  redirect address; sampled when `redirect`=1.
- `stall`  in  1  downstream hold (`reg_lock`); head is not consumed while 1.
- `instr_valid`  out  1  FIFO non-empty.
- `instr`  out  32  head instruction; 0 when `instr_valid`=0.
- `pc_plus_four`  out  32  head entry's address + 4; 0 when `instr_valid`=0.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states: IDLE, REQ, WAIT, DISCARD. `mem_req` = (state==REQ), decoded combinationally from the state register.
- IDLE:
  - `redirect` → `fetch_pc`=`target`, stay IDLE.
  - Otherwise, if `count`<DEPTH → REQ.
- REQ: `redirect` → `fetch_pc`=`target`, go to DISCARD. Otherwise go to WAIT.
- WAIT:
  - `mem_ack` with no `redirect` → push {`mem_rdata`, `fetch_pc`+4}, `fetch_pc`+=4, go to IDLE.
  - `mem_ack` with `redirect` → drop the data, `fetch_pc`=`target`, go to IDLE.
  - `redirect` with no `mem_ack` → `fetch_pc`=`target`, go to DISCARD.
- DISCARD: waits for the stale ack.
  - `mem_ack` → drop the data, go to IDLE.
  - `redirect` → update `fetch_pc`=`target`, regardless of `mem_ack`.
- Pop: occurs when `instr_valid` && !`stall` && !`redirect`.
- Redirect priority: `redirect` flushes the FIFO in the same edge (pointers and `count` go to 0) and suppresses that cycle's push and pop.
- Push and pop in the same cycle: `count` is unchanged; both pointers advance.
- Full: a REQ is issued only when `count`<DEPTH. No pop is needed while in flight, so a slot is always reserved and push never overflows.
- Pointer and `fetch_pc` arithmetic: pointers wrap modulo DEPTH; `fetch_pc` wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- `mem_ack` is ignored in IDLE and REQ; memory never acks in the REQ cycle.

## Timing
- Reset (async, immediate):
  - state=IDLE, `fetch_pc`=RESET_PC, FIFO empty.
  - `mem_req`=0, `mem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `pc_plus_four`=0, `count`=0.
- After `rst_n` rises: first edge moves IDLE→REQ, so `mem_req`=1 in cycle 1.
- Minimum fetch latency: REQ at cycle n, `mem_ack` at n+1, `instr_valid`=1 at n+2.
- Peak throughput with 1-cycle memory: one instruction per 3 cycles.
- Outputs `instr`, `pc_plus_four` and `instr_valid` reflect the registered FIFO head. They have no combinational path from `mem_rdata`.
- `redirect` at cycle n: FIFO is empty and `mem_addr`=`target` from n+1. If the state goes to IDLE, the next `mem_req` is at n+2.
- Reset mid-WAIT or mid-DISCARD: an ack arriving after reset is ignored, because state is IDLE.

## Test plan
- Reset check, RESET_PC=0:
  - Hold `rst_n`=0 → `mem_req`=0, `count`=0, `instr_valid`=0.
  - Release → `mem_req`=1 in cycle 1 with `mem_addr`=0.
- Streaming, 1-cycle ack, `stall`=0, memory returns 0x1000_0000+addr:
  - Heads appear with `instr`=0x1000_0000/`pc_plus_four`=4, then 0x1000_0004/8, then 0x1000_0008/12.
  - Spacing is 3 cycles.
- Full and drain, DEPTH=4:
  - Hold `stall`=1 → `count` reaches 4, `mem_req` stays 0, `mem_addr`=0x10.
  - Drop `stall` → heads 0,4,8,C are popped one per cycle, then fetching resumes at 0x10.
- Redirect in WAIT to `target`=0x100:
  - FIFO flushes, `count`=0, FSM enters DISCARD.
  - The ack 2 cycles later is dropped; the next `mem_req` has `mem_addr`=0x100, and the first head has `pc_plus_four`=0x104.
- Redirect coincident with `mem_ack` in WAIT, `target`=0x200:
  - The ack data is not pushed; there is no DISCARD.
  - `mem_req` with `mem_addr`=0x200 occurs 2 cycles later.
- Async reset asserted mid-WAIT:
  - Outputs clear without waiting for a clock edge.
  - An ack after release is ignored.
  - Fetch restarts at RESET_PC.
